// File: rtl/t_pulse_debouncer.sv
// t_pulse_debouncer
//   Turns a raw, asynchronous, bouncing push-button into clean one-cycle
//   toggle pulses for the T input of the downstream toggle flip-flop.
//   Pipeline: 2-FF synchronizer -> debounce FSM -> optional hold-to-repeat.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   btn_in         in   raw button level (asynchronous, may bounce)
//   t_pulse        out  registered one-cycle pulse on a press or a repeat
//   btn_stable     out  registered debounced button level
//   repeat_active  out  high while in the repeat-period phase of a hold
//   press_count    out  confirmed presses (repeats excluded), wraps 255 -> 0
//
// States
//   state        | meaning
//   -------------+------------------------------------------------------
//   IDLE         | button released and stable, waiting for a high sample
//   PRESS_CHK    | counting consecutive high samples before accepting
//   HELD         | press accepted; repeat timer runs while held
//   RELEASE_CHK  | counting consecutive low samples; repeat timer frozen
//
// Both timers are down-counters loaded with (length - 1) and acted on at
// zero, which gives the same edge timing as counting up from 0 to length-1.

module t_pulse_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       t_pulse,
    output logic       btn_stable,
    output logic       repeat_active,
    output logic [7:0] press_count
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic             t_pulse_nxt;
    logic             btn_stable_nxt;
    logic             repeat_active_nxt;
    logic [7:0]       press_count_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            rpt_cnt       <= '0;
            t_pulse       <= 1'b0;
            btn_stable    <= 1'b0;
            repeat_active <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            sync1         <= btn_in;
            sync2         <= sync1;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            rpt_cnt       <= rpt_cnt_nxt;
            t_pulse       <= t_pulse_nxt;
            btn_stable    <= btn_stable_nxt;
            repeat_active <= repeat_active_nxt;
            press_count   <= press_count_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        rpt_cnt_nxt       = rpt_cnt;
        t_pulse_nxt       = 1'b0;
        btn_stable_nxt    = btn_stable;
        repeat_active_nxt = repeat_active;
        press_count_nxt   = press_count;

        case (state)
            IDLE: begin
                if (sync2) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = CNT_LOAD;
                end
            end

            // A low sample is tested before the terminal count so a bounce
            // landing on the terminal edge still rejects the press.
            PRESS_CHK: begin
                if (!sync2) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt       = HELD;
                    t_pulse_nxt     = 1'b1;
                    btn_stable_nxt  = 1'b1;
                    press_count_nxt = press_count + 8'd1;
                    rpt_cnt_nxt     = DELAY_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            // repeat_active is always 0 on entry from PRESS_CHK, so the
            // first interval loaded is the initial delay; each repeat then
            // reloads with the period.
            HELD: begin
                if (!sync2) begin
                    state_nxt = RELEASE_CHK;
                    cnt_nxt   = CNT_LOAD;
                end else if (REPEAT_EN != 0) begin
                    if (rpt_cnt == '0) begin
                        t_pulse_nxt       = 1'b1;
                        rpt_cnt_nxt       = PERIOD_LOAD;
                        repeat_active_nxt = 1'b1;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt - RPT_ONE;
                    end
                end
            end

            // A high sample here is a release glitch: go back to HELD with
            // the repeat timer exactly where it was left.
            RELEASE_CHK: begin
                if (sync2) begin
                    state_nxt = HELD;
                end else if (cnt == '0) begin
                    state_nxt         = IDLE;
                    btn_stable_nxt    = 1'b0;
                    repeat_active_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_t_pulse_debouncer.sv
module tb_t_pulse_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_in;

    logic       a_t_pulse, a_btn_stable, a_repeat_active;
    logic [7:0] a_press_count;
    logic       b_t_pulse, b_btn_stable, b_repeat_active;
    logic [7:0] b_press_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int a_pulses = 0;
    int b_pulses = 0;
    int exp_a[$];
    int exp_b[$];
    int ea;
    int eb;
    int b;

    t_pulse_debouncer #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) u_rep (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .t_pulse(a_t_pulse), .btn_stable(a_btn_stable),
        .repeat_active(a_repeat_active), .press_count(a_press_count)
    );

    t_pulse_debouncer #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) u_one (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .t_pulse(b_t_pulse), .btn_stable(b_btn_stable),
        .repeat_active(b_repeat_active), .press_count(b_press_count)
    );

    always #5 clk = ~clk;

    // cyc counts rising edges; a pulse registered on edge e after the
    // stimulus negedge at cyc=b is seen at the next negedge with cyc=b+1+e.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every observed pulse pops the next expected pulse cycle.
    always @(negedge clk) begin
        if (a_t_pulse === 1'b1) begin
            a_pulses++;
            if (exp_a.size() > 0) ea = exp_a.pop_front();
            else ea = -1;
            check("a_pulse_cycle", cyc, ea);
        end
        if (b_t_pulse === 1'b1) begin
            b_pulses++;
            if (exp_b.size() > 0) eb = exp_b.pop_front();
            else eb = -1;
            check("b_pulse_cycle", cyc, eb);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        btn_in = 1'b0;
        reset  = 1'b1;
        step(n);
        reset  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_pulse"},  32'(a_t_pulse), 0);
        check({tag, "_a_stable"}, 32'(a_btn_stable), 0);
        check({tag, "_a_ract"},   32'(a_repeat_active), 0);
        check({tag, "_a_count"},  32'(a_press_count), 0);
        check({tag, "_b_pulse"},  32'(b_t_pulse), 0);
        check({tag, "_b_stable"}, 32'(b_btn_stable), 0);
        check({tag, "_b_ract"},   32'(b_repeat_active), 0);
        check({tag, "_b_count"},  32'(b_press_count), 0);
    endtask

    task automatic push_both(input int c);
        exp_a.push_back(c);
        exp_b.push_back(c);
    endtask

    task automatic release_and_check(input string tag);
        btn_in = 1'b0;
        step(6);
        check({tag, "_rel_a_stable_hold"}, 32'(a_btn_stable), 1);
        check({tag, "_rel_b_stable_hold"}, 32'(b_btn_stable), 1);
        step(1);
        check({tag, "_rel_a_stable_fall"}, 32'(a_btn_stable), 0);
        check({tag, "_rel_b_stable_fall"}, 32'(b_btn_stable), 0);
        check({tag, "_rel_a_ract"},        32'(a_repeat_active), 0);
        step(3);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_a_missing"}, 32'(exp_a.size()), 0);
        check({tag, "_b_missing"}, 32'(exp_b.size()), 0);
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;

        // 1: clean press, pulse at edge 6, then clean release
        do_reset(2);
        check_zero("t1_reset");
        btn_in = 1'b1;
        b = cyc;
        push_both(b + 7);
        step(6);
        check("t1_a_stable_pre", 32'(a_btn_stable), 0);
        step(1);
        check("t1_a_stable", 32'(a_btn_stable), 1);
        check("t1_b_stable", 32'(b_btn_stable), 1);
        check("t1_a_count",  32'(a_press_count), 1);
        check("t1_a_ract",   32'(a_repeat_active), 0);
        step(5);
        release_and_check("t1");
        check_drained("t1");

        // 2: bounce rejected, 4-sample high rejected, 5-sample high accepted
        do_reset(2);
        btn_in = 1'b1; step(3);
        btn_in = 1'b0; step(1);
        btn_in = 1'b1; step(2);
        btn_in = 1'b0; step(10);
        check("t2_a_stable", 32'(a_btn_stable), 0);
        check("t2_a_count",  32'(a_press_count), 0);
        check("t2_b_count",  32'(b_press_count), 0);
        btn_in = 1'b1; step(4);
        btn_in = 1'b0; step(10);
        check("t2_short_a_count", 32'(a_press_count), 0);
        btn_in = 1'b1;
        b = cyc;
        push_both(b + 7);
        step(5);
        btn_in = 1'b0;
        step(6);
        check("t2_min_a_stable_hold", 32'(a_btn_stable), 1);
        step(1);
        check("t2_min_a_stable_fall", 32'(a_btn_stable), 0);
        check("t2_min_a_count",       32'(a_press_count), 1);
        step(4);
        check_drained("t2");

        // 3: 60-cycle hold, repeats at E+20 then every 8 (REPEAT_EN=1 only)
        do_reset(2);
        btn_in = 1'b1;
        b = cyc;
        exp_a.push_back(b + 7);
        exp_a.push_back(b + 27);
        exp_a.push_back(b + 35);
        exp_a.push_back(b + 43);
        exp_a.push_back(b + 51);
        exp_a.push_back(b + 59);
        exp_b.push_back(b + 7);
        step(26);
        check("t3_a_ract_pre", 32'(a_repeat_active), 0);
        step(1);
        check("t3_a_ract",     32'(a_repeat_active), 1);
        check("t3_b_ract",     32'(b_repeat_active), 0);
        step(33);
        check("t3_a_count", 32'(a_press_count), 1);
        check("t3_b_count", 32'(b_press_count), 1);
        release_and_check("t3");
        check_drained("t3");

        // 4: 2-cycle release glitch in HELD freezes the repeat timer 3 edges
        do_reset(2);
        btn_in = 1'b1;
        b = cyc;
        exp_a.push_back(b + 7);
        exp_a.push_back(b + 30);
        exp_a.push_back(b + 38);
        exp_b.push_back(b + 7);
        step(10);
        btn_in = 1'b0;
        step(2);
        btn_in = 1'b1;
        step(2);
        check("t4_a_glitch_stable", 32'(a_btn_stable), 1);
        check("t4_b_glitch_stable", 32'(b_btn_stable), 1);
        step(15);
        check("t4_a_ract_pre", 32'(a_repeat_active), 0);
        step(1);
        check("t4_a_ract",     32'(a_repeat_active), 1);
        step(10);
        release_and_check("t4");
        check_drained("t4");

        // 5a: reset mid-PRESS_CHK with button held
        do_reset(2);
        btn_in = 1'b1;
        b = cyc;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_zero("t5a_after_reset");
        push_both(b + 12);
        step(12);
        check("t5a_a_count",  32'(a_press_count), 1);
        check("t5a_b_count",  32'(b_press_count), 1);
        check("t5a_a_stable", 32'(a_btn_stable), 1);
        release_and_check("t5a");
        check_drained("t5a");

        // 5b: reset mid-HELD with button held
        do_reset(2);
        btn_in = 1'b1;
        b = cyc;
        push_both(b + 7);
        step(10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_zero("t5b_after_reset");
        push_both(b + 18);
        step(10);
        check("t5b_a_count",  32'(a_press_count), 1);
        check("t5b_b_count",  32'(b_press_count), 1);
        check("t5b_a_stable", 32'(a_btn_stable), 1);
        release_and_check("t5b");
        check_drained("t5b");

        // 6: 257 clean presses, press_count wraps 255 -> 0 -> 1
        do_reset(2);
        a_pulses = 0;
        b_pulses = 0;
        for (int k = 1; k <= 257; k++) begin
            btn_in = 1'b1;
            b = cyc;
            push_both(b + 7);
            step(7);
            check("t6_a_count", 32'(a_press_count), 32'(k % 256));
            check("t6_b_count", 32'(b_press_count), 32'(k % 256));
            step(1);
            btn_in = 1'b0;
            step(8);
        end
        check("t6_a_pulses", a_pulses, 257);
        check("t6_b_pulses", b_pulses, 257);
        check_drained("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
